// File: rtl/pwm_pkg.sv
// Shared widths, defaults and config field positions for the
// four-channel dithered PWM block.
package pwm_pkg;

    localparam int CCW_DEF  = 8;
    localparam int FULL_DEF = 156;

    localparam int CFG_W  = 24;
    localparam int BASE_W = 8;
    localparam int DITH_W = 16;
    localparam int BCNT_W = 4;

    localparam int BASE_HI = 23;
    localparam int BASE_LO = 16;
    localparam int DITH_HI = 15;
    localparam int DITH_LO = 0;

endpackage

// File: rtl/red_pitaya_pwm_ch.sv
// One PWM channel: frame-latched base/dither, per-period threshold,
// compare against the shared period counter, registered output.
module red_pitaya_pwm_ch
    import pwm_pkg::*;
#(
    parameter int CCW = CCW_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [CFG_W-1:0]  cfg_i,
    input  logic [CCW-1:0]    pcnt_i,
    input  logic [BCNT_W-1:0] bcnt_i,
    input  logic              frame_ld_i,
    output logic              pwm_o
);

    // Compare width covers both the counter and the 9-bit threshold
    localparam int CW = (CCW > BASE_W + 1) ? CCW : BASE_W + 1;

    logic [BASE_W-1:0] base_q, base_d;
    logic [DITH_W-1:0] dith_q, dith_d;
    logic              pwm_q, pwm_d;
    logic [CW-1:0]     thr;
    logic [CW-1:0]     pc_x;

    always_comb begin
        base_d = base_q;
        dith_d = dith_q;
        if (frame_ld_i) begin
            base_d = cfg_i[BASE_HI:BASE_LO];
            dith_d = cfg_i[DITH_HI:DITH_LO];
        end
        thr   = CW'(base_q) + CW'(dith_q[bcnt_i]);
        pc_x  = CW'(pcnt_i);
        pwm_d = (pc_x < thr);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            base_q <= '0;
            dith_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            dith_q <= dith_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/red_pitaya_pwm_quad.sv
// Four-channel dithered PWM generator: shared period/frame counters,
// period and frame strobes, four independent channels.
module red_pitaya_pwm_quad
    import pwm_pkg::*;
#(
    parameter int CCW  = CCW_DEF,
    parameter int FULL = FULL_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [CFG_W-1:0] cfg_a_i,
    input  logic [CFG_W-1:0] cfg_b_i,
    input  logic [CFG_W-1:0] cfg_c_i,
    input  logic [CFG_W-1:0] cfg_d_i,
    output logic [3:0]       pwm_o,
    output logic             pwm_s_o,
    output logic             frame_o
);

    localparam logic [CCW-1:0] PMAX = CCW'(FULL - 1);

    logic [CCW-1:0]    pcnt_q, pcnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              pwm_s_q, pwm_s_d;
    logic              frame_q, frame_d;
    logic              last;
    logic              frame_ld;
    logic [CFG_W-1:0]  cfg [4];

    always_comb begin
        last     = (pcnt_q == PMAX);
        frame_ld = last && (bcnt_q == '1);
        pcnt_d   = last ? '0 : pcnt_q + CCW'(1);
        bcnt_d   = last ? bcnt_q + BCNT_W'(1) : bcnt_q;
        pwm_s_d  = last;
        frame_d  = frame_ld;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pcnt_q  <= '0;
            bcnt_q  <= '0;
            pwm_s_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            bcnt_q  <= bcnt_d;
            pwm_s_q <= pwm_s_d;
            frame_q <= frame_d;
        end
    end

    assign cfg[0] = cfg_a_i;
    assign cfg[1] = cfg_b_i;
    assign cfg[2] = cfg_c_i;
    assign cfg[3] = cfg_d_i;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        red_pitaya_pwm_ch #(
            .CCW(CCW)
        ) u_ch (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .cfg_i      (cfg[g]),
            .pcnt_i     (pcnt_q),
            .bcnt_i     (bcnt_q),
            .frame_ld_i (frame_ld),
            .pwm_o      (pwm_o[g])
        );
    end

    assign pwm_s_o = pwm_s_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_red_pitaya_pwm_quad.sv
// Self-checking bench for red_pitaya_pwm_quad: directed scenarios
// plus randomized free run against a cycle-index reference model.
module tb_red_pitaya_pwm_quad;

    localparam int FULL = 156;
    localparam int FLEN = 16 * FULL;

    logic        clk;
    logic        rstn;
    logic [23:0] cfg_a, cfg_b, cfg_c, cfg_d;
    logic [3:0]  pwm;
    logic        pwm_s;
    logic        frame;

    int n_cmp = 0;
    int n_bad = 0;

    red_pitaya_pwm_quad dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .cfg_a_i (cfg_a),
        .cfg_b_i (cfg_b),
        .cfg_c_i (cfg_c),
        .cfg_d_i (cfg_d),
        .pwm_o   (pwm),
        .pwm_s_o (pwm_s),
        .frame_o (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position in the frame follows from the number of
    // cycles since reset; config in force is the one seen at the
    // previous frame end.
    int unsigned t;
    logic [23:0] act [4];
    logic [23:0] cur [4];
    logic [3:0]  exp_pwm;
    logic        exp_s;
    logic        exp_f;

    always @(posedge clk) begin
        int p, b, thr;
        if (!rstn) begin
            t = 0;
            for (int i = 0; i < 4; i++) act[i] = '0;
            exp_pwm = '0;
            exp_s = 1'b0;
            exp_f = 1'b0;
        end else begin
            cur[0] = cfg_a;
            cur[1] = cfg_b;
            cur[2] = cfg_c;
            cur[3] = cfg_d;
            p = int'(t % FULL);
            b = int'((t / FULL) % 16);
            for (int i = 0; i < 4; i++) begin
                thr = int'(act[i][23:16]) + int'(act[i][b]);
                exp_pwm[i] = (p < thr);
            end
            exp_s = (p == FULL - 1);
            exp_f = exp_s && (b == 15);
            if (exp_f)
                for (int i = 0; i < 4; i++) act[i] = cur[i];
            t++;
        end
    end

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < FLEN + 100; k++) begin
            @(negedge clk);
            if (frame) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cfg_a = 24'($urandom());
        cfg_b = 24'($urandom());
        cfg_c = 24'($urandom());
        cfg_d = 24'($urandom());
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pwm, pwm_s, frame} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_out got=%b want=000000",
                     {pwm, pwm_s, frame});
        end
        rstn = 1'b1;
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pwm !== 4'h0 || frame !== (k == FLEN)) begin
                n_bad++;
                $display("FAIL first_frame k=%0d pwm=%h f=%b", k, pwm,
                         frame);
            end
        end
    endtask

    task automatic test_duty_a();
        bit ok;
        int cnt;
        cfg_a = 24'h0F_0000;
        cfg_b = 24'($urandom());
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL duty_a_timeout got=0 want=1");
        end
        for (int per = 0; per < 2; per++) begin
            cnt = 0;
            for (int k = 1; k <= FULL; k++) begin
                @(negedge clk);
                cnt += int'(pwm[0]);
                n_cmp++;
                if (pwm[0] !== (k <= 15)) begin
                    n_bad++;
                    $display("FAIL duty_a_bit k=%0d got=%b want=%b", k,
                             pwm[0], (k <= 15));
                end
                n_cmp++;
                if ({pwm, pwm_s, frame} !== {exp_pwm, exp_s, exp_f}) begin
                    n_bad++;
                    $display("FAIL duty_a_model got=%b want=%b",
                             {pwm, pwm_s, frame}, {exp_pwm, exp_s, exp_f});
                end
            end
            n_cmp++;
            if (cnt != 15) begin
                n_bad++;
                $display("FAIL duty_a_count got=%0d want=15", cnt);
            end
        end
    endtask

    task automatic test_dither_b();
        bit ok;
        int cnt, tot;
        cfg_b = 24'h4E_0001;
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL dither_b_timeout got=0 want=1");
        end
        tot = 0;
        for (int per = 0; per < 16; per++) begin
            cnt = 0;
            for (int k = 0; k < FULL; k++) begin
                @(negedge clk);
                cnt += int'(pwm[1]);
            end
            tot += cnt;
            n_cmp++;
            if (cnt != ((per == 0) ? 79 : 78)) begin
                n_bad++;
                $display("FAIL dither_b_period b=%0d got=%0d want=%0d",
                         per, cnt, (per == 0) ? 79 : 78);
            end
        end
        n_cmp++;
        if (tot != 1249) begin
            n_bad++;
            $display("FAIL dither_b_total got=%0d want=1249", tot);
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int cnt;
        cfg_c = 24'hFF_FFFF;
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL ext_hi_timeout got=0 want=1");
        end
        cnt = 0;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            cnt += int'(pwm[2]);
        end
        n_cmp++;
        if (cnt != FLEN) begin
            n_bad++;
            $display("FAIL ext_hi_count got=%0d want=%0d", cnt, FLEN);
        end
        cfg_c = 24'h00_0000;
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL ext_lo_timeout got=0 want=1");
        end
        cnt = 0;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            cnt += int'(pwm[2]);
        end
        n_cmp++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL ext_lo_count got=%0d want=0", cnt);
        end
    endtask

    task automatic test_midframe_change();
        bit ok;
        int ps, cnt, k;
        cfg_d = 24'h9C_0000;
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL mid_d_timeout got=0 want=1");
        end
        ps = 0;
        k = 0;
        while (ps < 5 && k < FLEN) begin
            @(negedge clk);
            k++;
            if (pwm_s) ps++;
        end
        cfg_d = 24'h10_0000;
        ok = 1'b0;
        cnt = 0;
        for (int j = 0; j < FLEN; j++) begin
            @(negedge clk);
            if (pwm[3] !== 1'b1) cnt++;
            if (frame) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || cnt != 0) begin
            n_bad++;
            $display("FAIL mid_d_hold frame=%b lows=%0d want_lows=0", ok,
                     cnt);
        end
        cnt = 0;
        for (int j = 0; j < FULL; j++) begin
            @(negedge clk);
            cnt += int'(pwm[3]);
        end
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL mid_d_new got=%0d want=16", cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cfg_a = 24'hFF_FFFF;
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rst_mid_timeout got=0 want=1");
        end
        repeat (77) @(negedge clk);
        n_cmp++;
        if (pwm[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre got=%b want=1", pwm[0]);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_cmp++;
        if ({pwm, pwm_s, frame} !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_mid_out got=%b want=000000",
                     {pwm, pwm_s, frame});
        end
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pwm !== 4'h0 || pwm_s !== (k % FULL == 0) ||
                frame !== (k == FLEN)) begin
                n_bad++;
                $display("FAIL rst_mid_run k=%0d got=%b", k,
                         {pwm, pwm_s, frame});
            end
        end
    endtask

    task automatic test_free_run();
        int last_s, last_f, ns, nf;
        last_s = -1;
        last_f = -1;
        ns = 0;
        nf = 0;
        for (int k = 0; k < 3 * FLEN; k++) begin
            if ($urandom_range(299) == 0) begin
                case ($urandom_range(3))
                    0: cfg_a = 24'($urandom());
                    1: cfg_b = 24'($urandom());
                    2: cfg_c = 24'($urandom());
                    default: cfg_d = 24'($urandom());
                endcase
            end
            @(negedge clk);
            n_cmp++;
            if ({pwm, pwm_s, frame} !== {exp_pwm, exp_s, exp_f}) begin
                n_bad++;
                $display("FAIL free_model k=%0d got=%b want=%b", k,
                         {pwm, pwm_s, frame}, {exp_pwm, exp_s, exp_f});
            end
            if (pwm_s) begin
                ns++;
                if (last_s >= 0) begin
                    n_cmp++;
                    if (k - last_s != FULL) begin
                        n_bad++;
                        $display("FAIL free_s_gap got=%0d want=%0d",
                                 k - last_s, FULL);
                    end
                end
                last_s = k;
            end
            if (frame) begin
                nf++;
                n_cmp++;
                if (pwm_s !== 1'b1) begin
                    n_bad++;
                    $display("FAIL free_f_s got=%b want=1", pwm_s);
                end
                if (last_f >= 0) begin
                    n_cmp++;
                    if (k - last_f != FLEN) begin
                        n_bad++;
                        $display("FAIL free_f_gap got=%0d want=%0d",
                                 k - last_f, FLEN);
                    end
                end
                last_f = k;
            end
        end
        n_cmp++;
        if (ns != 48 || nf != 3) begin
            n_bad++;
            $display("FAIL free_counts s=%0d f=%0d want=48/3", ns, nf);
        end
    endtask

    initial begin
        rstn  = 1'b0;
        cfg_a = '0;
        cfg_b = '0;
        cfg_c = '0;
        cfg_d = '0;
        test_reset();
        test_duty_a();
        test_dither_b();
        test_extremes();
        test_midframe_change();
        test_reset_mid();
        test_free_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
